// File: rtl/pe_network_interface.sv
// PE-side endpoint of the router PE port: queued TX with toggle signalling and
// ack/timeout retry, plus a single-entry RX holding buffer with sticky overflow.
module pe_network_interface #(
  parameter int X_LOCAL     = 2,
  parameter int Y_LOCAL     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        tx_valid_din,
  output logic        tx_ready_dout,
  input  logic [3:0]  tx_dest_x_din,
  input  logic [3:0]  tx_dest_y_din,
  input  logic [31:0] tx_payload_din,
  output logic        rx_valid_dout,
  input  logic        rx_ready_din,
  output logic [3:0]  rx_src_x_dout,
  output logic [3:0]  rx_src_y_dout,
  output logic [31:0] rx_payload_dout,
  output logic        rx_overflow_dout,
  output logic [47:0] pe_channel_dout,
  output logic [1:0]  pe_diff_pair_dout,
  input  logic        r2pe_ack_din,
  input  logic [39:0] pe_channel_din,
  input  logic [1:0]  pe_diff_pair_din
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  state_t state, state_nxt;

  logic [39:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [TW-1:0] timer;
  logic          push, pop, send, retoggle;
  logic [47:0]   head_flit;
  logic [1:0]    rx_last;
  logic          rx_new;

  assign push      = tx_valid_din & tx_ready_dout;
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign head_flit = {mem[rd_ptr][39:32], 4'(X_LOCAL), 4'(Y_LOCAL), mem[rd_ptr][31:0]};

  always_ff @(posedge clka) begin
    if (!rsta) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    send      = 1'b0;
    retoggle  = 1'b0;
    case (state)
      IDLE:     if (count != '0) state_nxt = SEND;
      SEND: begin
        send      = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // ack beats a coinciding timeout; occupancy after pop includes a same-cycle push
        if (r2pe_ack_din) begin
          pop       = 1'b1;
          state_nxt = (count > (AW+1)'(1) || push) ? SEND : IDLE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          retoggle = 1'b1;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= {tx_dest_x_din, tx_dest_y_din, tx_payload_din};
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      tx_ready_dout     <= 1'b1;
      timer             <= '0;
      pe_channel_dout   <= '0;
      pe_diff_pair_dout <= 2'b01;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_nxt;
      tx_ready_dout <= (count_nxt != (AW+1)'(FIFO_DEPTH));
      if (send) begin
        pe_channel_dout   <= head_flit;
        pe_diff_pair_dout <= ~pe_diff_pair_dout;
        timer             <= '0;
      end else if (retoggle) begin
        pe_diff_pair_dout <= ~pe_diff_pair_dout;
        timer             <= '0;
      end else if (state == WAIT_ACK) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // only the legal codes can signal a flit; 00/11 never move rx_last
  assign rx_new = ((pe_diff_pair_din == 2'b01) || (pe_diff_pair_din == 2'b10)) &&
                  (pe_diff_pair_din != rx_last);

  always_ff @(posedge clka) begin
    if (!rsta) begin
      rx_last          <= 2'b01;
      rx_valid_dout    <= 1'b0;
      rx_src_x_dout    <= '0;
      rx_src_y_dout    <= '0;
      rx_payload_dout  <= '0;
      rx_overflow_dout <= 1'b0;
    end else if (rx_new) begin
      rx_last <= pe_diff_pair_din;
      if (!rx_valid_dout || rx_ready_din) begin
        rx_src_x_dout   <= pe_channel_din[39:36];
        rx_src_y_dout   <= pe_channel_din[35:32];
        rx_payload_dout <= pe_channel_din[31:0];
        rx_valid_dout   <= 1'b1;
      end else begin
        rx_overflow_dout <= 1'b1;
      end
    end else if (rx_ready_din) begin
      rx_valid_dout <= 1'b0;
    end
  end
endmodule
